// File: rtl/rate_scaler_pkg.sv
// rtl/rate_scaler_pkg.sv - shared widths, record layout and record packing for the rate scaler readout
//
// Purpose: constants and helpers shared by the readout top, its FIFO and its bus interface.
// Record layout (LSB first): [dead_cnt (only when dead counting is built in)] [cnt] [seq].
// Ports: none (package).
package rate_scaler_pkg;

  localparam int SEQ_W     = 8;
  localparam int DROP_W    = 8;
  localparam int MAX_N_W   = 32;
  localparam int REC_MAX_W = SEQ_W + 2 * MAX_N_W;

  function automatic int cnt_lsb(input int n_w, input bit dead_en);
    return dead_en ? n_w : 0;
  endfunction

  function automatic int seq_lsb(input int n_w, input bit dead_en);
    return cnt_lsb(n_w, dead_en) + n_w;
  endfunction

  function automatic int rec_w(input int n_w, input bit dead_en);
    return SEQ_W + (dead_en ? 2 : 1) * n_w;
  endfunction

  // Builds a record in the low rec_w() bits of a maximum-width vector;
  // callers truncate to their own record width.
  function automatic logic [REC_MAX_W-1:0] pack_record(
    input logic [SEQ_W-1:0]   seq,
    input logic [MAX_N_W-1:0] cnt_v,
    input logic [MAX_N_W-1:0] dead_v,
    input int                 n_w,
    input bit                 dead_en
  );
    logic [REC_MAX_W-1:0] mask;
    logic [REC_MAX_W-1:0] rec;
    mask = (REC_MAX_W'(1) << n_w) - REC_MAX_W'(1);
    rec  = (REC_MAX_W'(seq) << seq_lsb(n_w, dead_en))
         | ((REC_MAX_W'(cnt_v) & mask) << cnt_lsb(n_w, dead_en));
    if (dead_en) begin
      rec = rec | (REC_MAX_W'(dead_v) & mask);
    end
    return rec;
  endfunction

endpackage

// File: rtl/rate_scaler_readout_if.sv
// rtl/rate_scaler_readout_if.sv - valid/ready readout bus carrying one buffered record
//
// Purpose: groups the record handshake between the readout block and its consumer.
// Signals: out_valid (head present), out_ready (consumer accepts), out_seq, out_cnt, out_dead_cnt.
// Modports: master = readout block (drives record), slave = consumer (drives out_ready).
interface rate_scaler_readout_if
  import rate_scaler_pkg::*;
#(
  parameter int P_N_WIDTH = 16
);

  logic                 out_valid;
  logic                 out_ready;
  logic [SEQ_W-1:0]     out_seq;
  logic [P_N_WIDTH-1:0] out_cnt;
  logic [P_N_WIDTH-1:0] out_dead_cnt;

  modport master (
    output out_valid, out_seq, out_cnt, out_dead_cnt,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_seq, out_cnt, out_dead_cnt,
    output out_ready
  );

endinterface

// File: rtl/rate_fifo.sv
// rtl/rate_fifo.sv - synchronous first-word-fall-through FIFO for readout records
//
// Purpose: holds up to 2^P_DEPTH_LOG2 records; the head is visible on dout while not empty.
// Ports: clk, rst_n (sync active-low); push/din/full write side; pop/dout/empty read side;
// level = occupancy 0..2^P_DEPTH_LOG2. A push while full is taken only if a pop happens in
// the same cycle; pop while empty is ignored.
module rate_fifo #(
  parameter int P_WIDTH      = 8,
  parameter int P_DEPTH_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [P_WIDTH-1:0]      din,
  output logic                    full,
  input  logic                    pop,
  output logic [P_WIDTH-1:0]      dout,
  output logic                    empty,
  output logic [P_DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << P_DEPTH_LOG2;
  localparam int LW    = P_DEPTH_LOG2 + 1;

  logic [P_WIDTH-1:0]      r_mem [DEPTH];
  logic [P_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [P_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [LW-1:0]           r_level;
  logic                    w_do_push;
  logic                    w_do_pop;

  assign empty     = (r_level == '0);
  assign full      = r_level[P_DEPTH_LOG2];
  assign level     = r_level;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + P_DEPTH_LOG2'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + P_DEPTH_LOG2'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/rate_scaler_readout.sv
// rtl/rate_scaler_readout.sv - captures rate scaler periods into a FIFO and serves them over valid/ready
//
// Purpose: on update&&valid a record {seq, cnt, dead cycles} is pushed; full-FIFO records are
// dropped and counted (the scaler is never back-pressured). seq advances on every capture.
// Ports: clk, rst_n (sync active-low); update, valid, cnt, dead from the scaler; clr_drop pulse;
// rd (master modport: out_valid/out_ready/out_seq/out_cnt/out_dead_cnt); level; drop_cnt.
// Build option: RATE_SCALER_READOUT_DEADCNT_EN compiles in the dead-cycle accumulator and its
// record field; without it out_dead_cnt is 0 and dead is unused.
module rate_scaler_readout
  import rate_scaler_pkg::*;
#(
  parameter int P_N_WIDTH    = 16,
  parameter int P_DEPTH_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      update,
  input  logic                      valid,
  input  logic [P_N_WIDTH-1:0]      cnt,
  input  logic                      dead,
  input  logic                      clr_drop,
  rate_scaler_readout_if.master     rd,
  output logic [P_DEPTH_LOG2:0]     level,
  output logic [DROP_W-1:0]         drop_cnt
);

`ifdef RATE_SCALER_READOUT_DEADCNT_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  localparam int REC_W   = rec_w(P_N_WIDTH, DEAD_EN);
  localparam int SEQ_LSB = seq_lsb(P_N_WIDTH, DEAD_EN);
  localparam int CNT_LSB = cnt_lsb(P_N_WIDTH, DEAD_EN);

  logic [SEQ_W-1:0]     r_seq;
  logic [DROP_W-1:0]    r_drop_cnt;
  logic [P_N_WIDTH-1:0] w_dead_acc_next;
  logic                 w_cap;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_accept;
  logic                 w_drop;
  logic [REC_W-1:0]     w_rec;
  logic [REC_W-1:0]     w_head;

  assign w_cap    = update && valid;
  assign w_pop    = rd.out_valid && rd.out_ready;
  // A full FIFO still takes the record when the head leaves in the same cycle.
  assign w_accept = w_cap && (!w_full || w_pop);
  assign w_drop   = w_cap && !w_accept;

`ifdef RATE_SCALER_READOUT_DEADCNT_EN
  logic [P_N_WIDTH-1:0] r_dead_acc;

  // Includes the update cycle itself, so the record covers the full period.
  assign w_dead_acc_next = (r_dead_acc == '1) ? r_dead_acc
                                              : r_dead_acc + P_N_WIDTH'(dead);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dead_acc <= '0;
    end else if (update) begin
      r_dead_acc <= '0;
    end else begin
      r_dead_acc <= w_dead_acc_next;
    end
  end
`else
  logic w_unused_dead;
  assign w_unused_dead   = dead;
  assign w_dead_acc_next = '0;
`endif

  assign w_rec = REC_W'(pack_record(r_seq, MAX_N_W'(cnt), MAX_N_W'(w_dead_acc_next),
                                    P_N_WIDTH, DEAD_EN));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seq      <= '0;
      r_drop_cnt <= '0;
    end else begin
      // Dropped records consume a sequence number so the reader can see the gap.
      if (w_cap) begin
        r_seq <= r_seq + SEQ_W'(1);
      end
      if (clr_drop) begin
        r_drop_cnt <= w_drop ? DROP_W'(1) : '0;
      end else if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end
  end

  rate_fifo #(
    .P_WIDTH      (REC_W),
    .P_DEPTH_LOG2 (P_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_accept),
    .din   (w_rec),
    .full  (w_full),
    .pop   (w_pop),
    .dout  (w_head),
    .empty (w_empty),
    .level (level)
  );

  // Fields are forced to 0 while empty so reset and idle both read as zero.
  assign rd.out_valid = !w_empty;
  assign rd.out_seq   = w_empty ? '0 : w_head[SEQ_LSB +: SEQ_W];
  assign rd.out_cnt   = w_empty ? '0 : w_head[CNT_LSB +: P_N_WIDTH];
`ifdef RATE_SCALER_READOUT_DEADCNT_EN
  assign rd.out_dead_cnt = w_empty ? '0 : w_head[0 +: P_N_WIDTH];
`else
  assign rd.out_dead_cnt = '0;
`endif

  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_rate_scaler_readout.sv
// tb/tb_rate_scaler_readout.sv - directed self-checking bench for rate_scaler_readout
module tb_rate_scaler_readout;

`ifdef RATE_SCALER_READOUT_DEADCNT_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        update;
  logic        valid;
  logic [15:0] cnt;
  logic        dead;
  logic        clr_drop;
  logic [3:0]  level;
  logic [7:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rate_scaler_readout_if #(.P_N_WIDTH(16)) rd ();

  rate_scaler_readout #(
    .P_N_WIDTH    (16),
    .P_DEPTH_LOG2 (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .update   (update),
    .valid    (valid),
    .cnt      (cnt),
    .dead     (dead),
    .clr_drop (clr_drop),
    .rd       (rd),
    .level    (level),
    .drop_cnt (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; update = 1'b1; valid = 1'b1; cnt = 16'hFFFF; dead = 1'b1; clr_drop = 1'b0;
    rd.out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", 32'(rd.out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_seq", 32'(rd.out_seq), 32'd0);
    check("rst_cnt", 32'(rd.out_cnt), 32'd0);
    check("rst_dead", 32'(rd.out_dead_cnt), 32'd0);

    update = 1'b0; valid = 1'b0; dead = 1'b0; cnt = '0; rd.out_ready = 1'b0;
    rst_n = 1'b1;

    // First record: five dead cycles in the period
    dead = 1'b1;
    repeat (5) tick();
    dead = 1'b0;
    repeat (2) tick();
    update = 1'b1; valid = 1'b1; cnt = 16'h1234;
    tick();
    update = 1'b0; valid = 1'b0;
    check("first_valid", 32'(rd.out_valid), 32'd1);
    check("first_seq", 32'(rd.out_seq), 32'd0);
    check("first_cnt", 32'(rd.out_cnt), 32'h1234);
    check("first_dead", 32'(rd.out_dead_cnt), DEAD_EN ? 32'd5 : 32'd0);
    rd.out_ready = 1'b1;
    tick();
    rd.out_ready = 1'b0;
    check("first_pop_valid", 32'(rd.out_valid), 32'd0);
    check("first_pop_level", 32'(level), 32'd0);

    // Ten captures into an undrained FIFO
    do_reset();
    for (int i = 0; i < 10; i++) begin
      update = 1'b1; valid = 1'b1; cnt = 16'h0100 + 16'(i);
      tick();
    end
    check("fill_level", 32'(level), 32'd8);
    check("fill_drop", 32'(drop_cnt), 32'd2);
    check("fill_head_seq", 32'(rd.out_seq), 32'd0);
    check("fill_head_cnt", 32'(rd.out_cnt), 32'h0100);

    // Full FIFO, capture and pop together
    cnt = 16'hAAAA; rd.out_ready = 1'b1;
    tick();
    update = 1'b0; valid = 1'b0;
    check("fullpp_level", 32'(level), 32'd8);
    check("fullpp_drop", 32'(drop_cnt), 32'd2);
    check("fullpp_head", 32'(rd.out_seq), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("drain_seq", 32'(rd.out_seq), (i < 7) ? 32'(i + 1) : 32'd10);
      if (i == 7) check("drain_last_cnt", 32'(rd.out_cnt), 32'hAAAA);
      tick();
    end
    check("drain_level", 32'(level), 32'd0);
    check("drain_valid", 32'(rd.out_valid), 32'd0);

    // 300 back-to-back captures with the consumer always ready: seq 11..310 mod 256
    for (int k = 0; k < 300; k++) begin
      update = 1'b1; valid = 1'b1; cnt = 16'(k);
      tick();
      check("wrap_seq", 32'(rd.out_seq), 32'((11 + k) % 256));
    end
    update = 1'b0; valid = 1'b0;
    tick();
    check("wrap_level", 32'(level), 32'd0);
    check("wrap_drop", 32'(drop_cnt), 32'd2);

    // update without valid: no record, seq kept, dead count restarts
    rd.out_ready = 1'b0;
    dead = 1'b1;
    repeat (3) tick();
    update = 1'b1; valid = 1'b0;
    tick();
    check("novalid_level", 32'(level), 32'd0);
    check("novalid_valid", 32'(rd.out_valid), 32'd0);
    update = 1'b0;
    repeat (2) tick();
    update = 1'b1; valid = 1'b1; cnt = 16'h0055;
    tick();
    update = 1'b0; valid = 1'b0; dead = 1'b0;
    check("novalid_seq", 32'(rd.out_seq), 32'd55);
    check("novalid_cnt", 32'(rd.out_cnt), 32'h0055);
    check("novalid_dead", 32'(rd.out_dead_cnt), DEAD_EN ? 32'd3 : 32'd0);
    rd.out_ready = 1'b1;
    tick();
    rd.out_ready = 1'b0;

    // Drop coinciding with clr_drop
    for (int i = 0; i < 8; i++) begin
      update = 1'b1; valid = 1'b1; cnt = 16'(i);
      tick();
    end
    check("clr_pre_drop", 32'(drop_cnt), 32'd2);
    clr_drop = 1'b1;
    tick();
    check("clr_drop_with_drop", 32'(drop_cnt), 32'd1);
    check("clr_level", 32'(level), 32'd8);
    update = 1'b0; valid = 1'b0;
    tick();
    clr_drop = 1'b0;
    check("clr_drop_alone", 32'(drop_cnt), 32'd0);

    // Drop counter saturation
    update = 1'b1; valid = 1'b1;
    repeat (300) tick();
    update = 1'b0; valid = 1'b0;
    check("sat_drop", 32'(drop_cnt), 32'd255);
    check("sat_level", 32'(level), 32'd8);

    // Reset with four records buffered
    rd.out_ready = 1'b1;
    repeat (4) tick();
    rd.out_ready = 1'b0;
    check("midrst_pre_level", 32'(level), 32'd4);
    do_reset();
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_valid", 32'(rd.out_valid), 32'd0);
    check("midrst_drop", 32'(drop_cnt), 32'd0);
    update = 1'b1; valid = 1'b1; cnt = 16'h0077;
    tick();
    update = 1'b0; valid = 1'b0;
    check("midrst_new_valid", 32'(rd.out_valid), 32'd1);
    check("midrst_new_seq", 32'(rd.out_seq), 32'd0);
    check("midrst_new_cnt", 32'(rd.out_cnt), 32'h0077);
    check("midrst_new_dead", 32'(rd.out_dead_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rate_scaler_readout.md
# rate_scaler_readout

Downstream consumer of the four-lane rate scaler. Captures each completed counting period (`cnt` on `update && valid`) together with a sequence number and an optional dead-cycle tally. Buffers these records in a small first-word-fall-through FIFO and presents them to the register/readout bus over a valid/ready handshake. Overflowing records are dropped and counted, never stalled, because the scaler cannot be back-pressured.

## Interface
Parameters:
- `P_N_WIDTH`, 16: width of rate count and dead-cycle count; matches the scaler's `cnt`.
- `P_DEPTH_LOG2`, 3: FIFO depth is 2^`P_DEPTH_LOG2` records (8).

Ports:
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: reset, synchronous, active-low.
- `update` in 1: period-end strobe from the scaler.
- `valid` in 1: scaler count valid.
- `cnt` in `P_N_WIDTH`: period count, sampled when `update` = 1.
- `dead` in 1: scaler dead-time level.
- `clr_drop` in 1: single-cycle pulse that clears `drop_cnt`.
- `out_valid` out 1: head record available.
- `out_ready` in 1: consumer accepts the head record.
- `out_seq` out 8: record sequence number.
- `out_cnt` out `P_N_WIDTH`: record rate count.
- `out_dead_cnt` out `P_N_WIDTH`: dead cycles in the record's period.
- `level` out `P_DEPTH_LOG2`+1: FIFO occupancy, 0..2^`P_DEPTH_LOG2`.
- `drop_cnt` out 8: records lost to a full FIFO.

## Operation
- Capture event: `cap = update && valid`.
  - Forms the record {`seq`, `cnt`, `dead_acc_next`}.
  - Then increments `seq` modulo 256. `seq` advances on dropped records too, so the reader sees gaps.
- `update && !valid`: no record is written. `seq` is unchanged. The dead accumulator still restarts.
- Dead accumulator:
  - Counts cycles with `dead` = 1, from the cycle after the previous `update` up to and including the current `update` cycle.
  - `dead_acc_next` = `dead_acc` + `dead`, saturating at all-ones.
  - On `update`, the accumulator restarts at 0.
- Push rule: a record is accepted if `level` < depth, or if a pop occurs in the same cycle (full with simultaneous pop → accepted).
- Drop rule: a record that is not accepted is discarded and increments `drop_cnt`, saturating at 255.
- `clr_drop` together with a drop in the same cycle → `drop_cnt` = 1.
- Pop: occurs when `out_valid && out_ready`.
- `out_ready` while empty has no effect.
- `out_seq`, `out_cnt`, `out_dead_cnt` are don't-care while `out_valid` = 0.
- `level` reflects push and pop in the same cycle; a simultaneous push and pop leaves it unchanged.
- Pointers wrap modulo depth. Full/empty are distinguished by the extra `level` bit.

## Timing
- Reset (`rst_n` = 0 at a `clk` edge) values:
  - `out_valid` = 0, `level` = 0, `drop_cnt` = 0, `seq` = 0, dead accumulator = 0.
  - Record fields read 0.
  - Inputs are ignored during reset.
- Reset mid-operation discards all buffered records. The first capture after release carries `seq` 0.
- Latency: a capture in cycle N is visible with `out_valid` = 1 in cycle N+1 if the FIFO was empty.
- Pop in cycle N presents the next record in cycle N+1. `out_valid` falls in N+1 if the FIFO is then empty.
- Head fields are stable while `out_valid` = 1 and `out_ready` = 0.
- Throughput: one push and one pop per cycle.

## Configuration
- `RATE_SCALER_READOUT_DEADCNT_EN`
  - Defined: dead accumulator and FIFO `out_dead_cnt` storage are compiled in, as described above.
  - Undefined: the accumulator and its FIFO field are removed, `out_dead_cnt` is tied to 0, and the `dead` input is unused.
  - All other behaviour is identical in both cases.

## Structure
- Shared package `rate_scaler_pkg`:
  - `SEQ_W` = 8, `DROP_W` = 8.
  - Record field offsets and a function building a packed record of width `SEQ_W` + `P_N_WIDTH`(×2 with `..._DEADCNT_EN`).
- Sub-module `rate_fifo`:
  - Parameterised synchronous FWFT FIFO (width, depth log2).
  - Ports: `push`/`full`, `pop`/`empty`, `level`.
- The top level holds the capture logic, `seq`, the dead accumulator and the drop counter.

## Test plan
- Reset, then `update`+`valid` with `cnt` = 0x1234 and `dead` high for 5 cycles of the period → next cycle `out_valid` = 1, `out_seq` = 0, `out_cnt` = 0x1234, `out_dead_cnt` = 5 (0 with macro undefined).
- `out_ready` held 0 and 10 captures → `level` = 8, `drop_cnt` = 2. Draining yields `seq` 0..7, in order.
- FIFO full, with a capture and a pop in the same cycle → record accepted, `level` stays 8, `drop_cnt` unchanged.
- 300 captures with `out_ready` = 1 → `out_seq` wraps 255→0 with no gaps. `drop_cnt` saturation is checked separately with ≥300 drops → 255.
- `update` with `valid` = 0 → no record and `seq` unchanged. `dead_cnt` restarts, so the next record counts only cycles after that `update`.
- Drop and `clr_drop` in the same cycle → `drop_cnt` = 1. `rst_n` low mid-stream with 4 records buffered → `level` = 0, and the next record has `seq` 0.
